// File: rtl/in_scan_ctrl_pkg.sv
// Shared definitions for the in_module scan controller.
// Contents: default sizes (NPORTS_DEF/AW_DEF/DW_DEF), FSM state encodings,
// and lowest_set(), which gives the index of the lowest set bit of a mask.
package in_scan_ctrl_pkg;

    localparam int NPORTS_DEF = 16;
    localparam int AW_DEF     = 4;
    localparam int DW_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_CAP  = 2'd2
    } scan_state_e;

    // Index of the lowest set bit; 0 if the mask is empty.
    function automatic int lowest_set(input logic [63:0] mask);
        logic [63:0] m;
        logic        found;
        int          r;
        m     = mask;
        found = 1'b0;
        r     = 0;
        for (int i = 0; i < 64; i++) begin
            if (!found && m[0]) begin
                r     = i;
                found = 1'b1;
            end
            m = m >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/in_scan_ctrl_if.sv
// CPU-read and change-event bus of the scan controller.
// CPU read : cpu_req/cpu_addr (requester -> controller), cpu_ack/cpu_data (back).
// Events   : evt_valid/evt_port/evt_data (controller -> consumer), evt_ready (back).
// Modports : slave = the controller, master = CPU side / event consumer.
interface in_scan_ctrl_if
    import in_scan_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic [DW-1:0] cpu_data;
    logic          evt_valid;
    logic          evt_ready;
    logic [AW-1:0] evt_port;
    logic [DW-1:0] evt_data;

    modport master (
        output cpu_req, cpu_addr, evt_ready,
        input  cpu_ack, cpu_data, evt_valid, evt_port, evt_data
    );

    modport slave (
        input  cpu_req, cpu_addr, evt_ready,
        output cpu_ack, cpu_data, evt_valid, evt_port, evt_data
    );
endinterface

// File: rtl/in_scan_ctrl_rr_pick.sv
// Round-robin picker over an N-bit request mask.
// Ports: req (candidates), last (previous winner), idx (first set bit after last,
// wrapping, with last itself lowest priority), any (req is nonzero).
// N must equal 2**AW so that index arithmetic wraps naturally.
module in_scan_ctrl_rr_pick
    import in_scan_ctrl_pkg::*;
#(
    parameter int N  = NPORTS_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] last,
    output logic [AW-1:0] idx,
    output logic          any
);

    // Walk from the farthest candidate (last itself) down to last+1 so the nearest set bit wins.
    always_comb begin
        logic [AW-1:0] jj;
        jj  = '0;
        idx = '0;
        any = |req;
        for (int k = N; k >= 1; k--) begin
            jj  = last + AW'(k);
            idx = req[jj] ? jj : idx;
        end
    end

endmodule

// File: rtl/in_scan_ctrl.sv
// Controller for in_module (NPORTS-port DW-bit input mux).
// Round-robin scans the ports in PORT_MASK, keeps a shadow copy of each port and reports
// value changes as events; also serves direct CPU port reads, alternating with scanning.
// Ports: clk, rst_n (sync, active low), scan_en; in_en/in_addr -> in_module,
// in_data <- in_module; bus (slave): CPU read and change-event handshakes.
module in_scan_ctrl
    import in_scan_ctrl_pkg::*;
#(
    parameter int                NPORTS    = NPORTS_DEF,
    parameter int                AW        = AW_DEF,
    parameter int                DW        = DW_DEF,
    parameter logic [NPORTS-1:0] PORT_MASK = {NPORTS{1'b1}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scan_en,
    output logic          in_en,
    output logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    in_scan_ctrl_if.slave bus
);

    localparam logic [AW-1:0] PTR_INIT = AW'(lowest_set(64'(PORT_MASK)));

    scan_state_e   state_r, state_s;
    logic          in_en_r, in_en_s;
    logic [AW-1:0] in_addr_r, in_addr_s;
    logic          slot_cpu_r, slot_cpu_s;   // type of the current (or most recent) slot
    logic [AW-1:0] ptr_r, ptr_nxt_s, ptr_adv_s;
    logic          ptr_any_s;
    logic          primed_r;
    logic [DW-1:0] shadow_r [NPORTS];
    logic [NPORTS-1:0] pending_r, pending_s, set_s, clr_s;
    logic          cpu_ack_r;
    logic [DW-1:0] cpu_data_r;
    logic          evt_valid_r;
    logic [AW-1:0] evt_port_r;
    logic [DW-1:0] evt_data_r;
    logic [AW-1:0] evt_idx_s;
    logic          evt_any_s, evt_load_s;
    logic          scan_cap_s, cap_s, cpu_req_s, take_cpu_s, take_scan_s;

    in_scan_ctrl_rr_pick #(.N(NPORTS), .AW(AW)) u_ptr_pick (
        .req  (PORT_MASK),
        .last (ptr_r),
        .idx  (ptr_adv_s),
        .any  (ptr_any_s)
    );

    in_scan_ctrl_rr_pick #(.N(NPORTS), .AW(AW)) u_evt_pick (
        .req  (pending_r),
        .last (evt_port_r),
        .idx  (evt_idx_s),
        .any  (evt_any_s)
    );

    // Slot arbitration inputs. cpu_req stays high until the ack cycle, so the request
    // being served (its CAP cycle or ack cycle) must not be taken as a new one.
    always_comb begin
        cap_s       = (state_r == ST_CAP);
        scan_cap_s  = cap_s && !slot_cpu_r;
        ptr_nxt_s   = scan_cap_s ? ptr_adv_s : ptr_r;
        cpu_req_s   = bus.cpu_req && !cpu_ack_r && !(cap_s && slot_cpu_r);
        take_cpu_s  = cpu_req_s && !(slot_cpu_r && scan_en);
        take_scan_s = scan_en && ptr_any_s;
    end

    // FSM next state and next in_module drive; slots start from IDLE or straight out of CAP.
    always_comb begin
        state_s    = state_r;
        in_en_s    = in_en_r;
        in_addr_s  = in_addr_r;
        slot_cpu_s = slot_cpu_r;
        case (state_r)
            ST_IDLE, ST_CAP: begin
                if (take_cpu_s) begin
                    state_s    = ST_SEL;
                    in_en_s    = 1'b1;
                    in_addr_s  = bus.cpu_addr;
                    slot_cpu_s = 1'b1;
                end else if (take_scan_s) begin
                    state_s    = ST_SEL;
                    in_en_s    = 1'b1;
                    in_addr_s  = ptr_nxt_s;
                    slot_cpu_s = 1'b0;
                end else begin
                    state_s    = ST_IDLE;
                    in_en_s    = 1'b0;
                end
            end
            ST_SEL: begin
                state_s = ST_CAP;
            end
            default: begin
                state_s = ST_IDLE;
                in_en_s = 1'b0;
            end
        endcase
    end

    // Pending change flags: a capture setting a bit beats the event loader clearing it.
    always_comb begin
        set_s = '0;
        clr_s = '0;
        if (cap_s && primed_r && (in_data != shadow_r[in_addr_r])) begin
            set_s[in_addr_r] = 1'b1;
        end else begin
            set_s = '0;
        end
        evt_load_s = evt_any_s && (!evt_valid_r || bus.evt_ready);
        if (evt_load_s) begin
            clr_s[evt_idx_s] = 1'b1;
        end else begin
            clr_s = '0;
        end
        pending_s = (pending_r & ~clr_s) | set_s;
    end

    // FSM state and registered in_module drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            in_en_r    <= 1'b0;
            in_addr_r  <= '0;
            slot_cpu_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_en_r    <= in_en_s;
            in_addr_r  <= in_addr_s;
            slot_cpu_r <= slot_cpu_s;
        end
    end

    // Scan pointer; the first wrap marks the shadow as fully loaded (primed).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r    <= PTR_INIT;
            primed_r <= 1'b0;
        end else begin
            ptr_r <= ptr_nxt_s;
            if (scan_cap_s && (ptr_adv_s <= ptr_r)) begin
                primed_r <= 1'b1;
            end
        end
    end

    // Shadow copies and pending flags; every capture refreshes the shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORTS; i++) begin
                shadow_r[i] <= '0;
            end
            pending_r <= '0;
        end else begin
            if (cap_s) begin
                shadow_r[in_addr_r] <= in_data;
            end
            pending_r <= pending_s;
        end
    end

    // CPU read response: one-cycle ack with the captured value right after CAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_ack_r  <= 1'b0;
            cpu_data_r <= '0;
        end else if (cap_s && slot_cpu_r) begin
            cpu_ack_r  <= 1'b1;
            cpu_data_r <= in_data;
        end else begin
            cpu_ack_r  <= 1'b0;
        end
    end

    // Event output register; contents held while waiting for ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_valid_r <= 1'b0;
            evt_port_r  <= '0;
            evt_data_r  <= '0;
        end else if (evt_load_s) begin
            evt_valid_r <= 1'b1;
            evt_port_r  <= evt_idx_s;
            evt_data_r  <= shadow_r[evt_idx_s];
        end else if (bus.evt_ready) begin
            evt_valid_r <= 1'b0;
        end
    end

    assign in_en         = in_en_r;
    assign in_addr       = in_addr_r;
    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.cpu_data  = cpu_data_r;
    assign bus.evt_valid = evt_valid_r;
    assign bus.evt_port  = evt_port_r;
    assign bus.evt_data  = evt_data_r;

endmodule

// File: tb/tb_in_scan_ctrl.sv
// Directed self-checking bench for in_scan_ctrl: a full-mask instance (dut) and a
// PORT_MASK=16'h0011 instance (dut_m), both fed by one in_module port model.
module tb_in_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       scan_en;
    logic       in_en, in_en_m;
    logic [3:0] in_addr, in_addr_m;
    logic [7:0] in_data, in_data_m;
    logic [7:0] ports [16];

    int tests_run;
    int tests_failed;
    int bad_addr_m;

    logic [3:0] ev_port   [$];
    logic [7:0] ev_data   [$];
    logic [3:0] ev_port_m [$];
    logic [7:0] ev_data_m [$];

    in_scan_ctrl_if #(.AW(4), .DW(8)) bus ();
    in_scan_ctrl_if #(.AW(4), .DW(8)) bus_m ();

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign in_data   = in_en   ? ports[in_addr]   : 8'h00;
    assign in_data_m = in_en_m ? ports[in_addr_m] : 8'h00;

    in_scan_ctrl #(.NPORTS(16), .AW(4), .DW(8), .PORT_MASK(16'hFFFF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scan_en (scan_en),
        .in_en   (in_en),
        .in_addr (in_addr),
        .in_data (in_data),
        .bus     (bus)
    );

    in_scan_ctrl #(.NPORTS(16), .AW(4), .DW(8), .PORT_MASK(16'h0011)) dut_m (
        .clk     (clk),
        .rst_n   (rst_n),
        .scan_en (scan_en),
        .in_en   (in_en_m),
        .in_addr (in_addr_m),
        .in_data (in_data_m),
        .bus     (bus_m)
    );

    // Record completed event handshakes; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
            ev_port.push_back(bus.evt_port);
            ev_data.push_back(bus.evt_data);
        end
        if (rst_n === 1'b1 && bus_m.evt_valid === 1'b1 && bus_m.evt_ready === 1'b1) begin
            ev_port_m.push_back(bus_m.evt_port);
            ev_data_m.push_back(bus_m.evt_data);
        end
        if (rst_n === 1'b1 && in_en_m === 1'b1 && in_addr_m !== 4'd0 && in_addr_m !== 4'd4) begin
            bad_addr_m++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        scan_en        = 1'b0;
        bus.cpu_req    = 1'b0;
        bus.cpu_addr   = 4'd0;
        bus.evt_ready  = 1'b0;
        bus_m.cpu_req  = 1'b0;
        bus_m.cpu_addr = 4'd0;
        bus_m.evt_ready = 1'b0;
        for (int i = 0; i < 16; i++) ports[i] = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        ev_port.delete();
        ev_data.delete();
        ev_port_m.delete();
        ev_data_m.delete();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        scan_en       = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 4'd3;
        bus.evt_ready = 1'b0;
        bus_m.cpu_req = 1'b1;
        bus_m.cpu_addr = 4'd4;
        bus_m.evt_ready = 1'b0;
        for (int i = 0; i < 16; i++) ports[i] = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if ({in_en, in_addr, bus.cpu_ack, bus.cpu_data, bus.evt_valid, bus.evt_port,
                 bus.evt_data} !== 27'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs: cycle %0d en=%b addr=%0d ack=%b cdata=%h v=%b p=%0d d=%h, required all 0",
                         c, in_en, in_addr, bus.cpu_ack, bus.cpu_data, bus.evt_valid, bus.evt_port, bus.evt_data);
            end
            tests_run++;
            if ({in_en_m, in_addr_m, bus_m.cpu_ack, bus_m.cpu_data, bus_m.evt_valid,
                 bus_m.evt_port, bus_m.evt_data} !== 27'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs_m: cycle %0d en=%b addr=%0d ack=%b, required all 0",
                         c, in_en_m, in_addr_m, bus_m.cpu_ack);
            end
        end
        bus.cpu_req   = 1'b0;
        bus_m.cpu_req = 1'b0;
        scan_en       = 1'b0;
    endtask

    task automatic test_cpu_read();
        apply_reset();
        ports[3]     = 8'h44;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 4'd3;
        for (int c = 1; c <= 2; c++) begin
            tick();
            tests_run++;
            if (in_en !== 1'b1 || in_addr !== 4'd3 || bus.cpu_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL cpu_slot: cycle %0d en=%b addr=%0d ack=%b, required en=1 addr=3 ack=0",
                         c, in_en, in_addr, bus.cpu_ack);
            end
        end
        tick();
        tests_run++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_data !== 8'h44) begin
            tests_failed++;
            $display("FAIL cpu_ack: cycle 3 ack=%b data=%h, required ack=1 data=44",
                     bus.cpu_ack, bus.cpu_data);
        end
        bus.cpu_req = 1'b0;
        tick();
        tests_run++;
        if (bus.cpu_ack !== 1'b0 || in_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpu_after: ack=%b en=%b, required ack=0 en=0", bus.cpu_ack, in_en);
        end
    endtask

    task automatic test_prime_change();
        apply_reset();
        ports[7]      = 8'h77;
        scan_en       = 1'b1;
        bus.evt_ready = 1'b1;
        repeat (36) tick();
        tests_run++;
        if (ev_port.size() != 0) begin
            tests_failed++;
            $display("FAIL prime_no_event: %0d events during priming, required 0", ev_port.size());
        end
        ports[5] = 8'hA5;
        repeat (40) tick();
        tests_run++;
        if (ev_port.size() != 1) begin
            tests_failed++;
            $display("FAIL change_count: %0d events, required 1", ev_port.size());
        end else begin
            tests_run++;
            if (ev_port[0] !== 4'd5 || ev_data[0] !== 8'hA5) begin
                tests_failed++;
                $display("FAIL change_event: port=%0d data=%h, required port=5 data=a5",
                         ev_port[0], ev_data[0]);
            end
        end
        scan_en = 1'b0;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_addr;
        logic       exp_ack;
        apply_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 4'd3;
        scan_en      = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            exp_addr = (k % 2 == 0) ? 4'd3 : 4'(k / 2);
            exp_ack  = (k % 2 == 1);
            tests_run++;
            if (in_en !== 1'b1 || in_addr !== exp_addr || bus.cpu_ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL fair_slot: slot %0d en=%b addr=%0d ack=%b, required en=1 addr=%0d ack=%b",
                         k, in_en, in_addr, bus.cpu_ack, exp_addr, exp_ack);
            end
            tick();
        end
        bus.cpu_req = 1'b0;
        scan_en     = 1'b0;
    endtask

    task automatic test_backpressure();
        logic       got;
        logic [3:0] hold_p;
        logic [7:0] hold_d;
        int         unstable;
        apply_reset();
        scan_en       = 1'b1;
        bus.evt_ready = 1'b1;
        repeat (36) tick();
        bus.evt_ready = 1'b0;
        ports[2] = 8'h22;
        ports[9] = 8'h99;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (bus.evt_valid === 1'b1) got = 1'b1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL bp_wait: evt_valid=0, required 1 within 40 cycles");
        end
        hold_p = bus.evt_port;
        hold_d = bus.evt_data;
        tests_run++;
        if (hold_p !== 4'd2 || hold_d !== 8'h22) begin
            tests_failed++;
            $display("FAIL bp_first: port=%0d data=%h, required port=2 data=22", hold_p, hold_d);
        end
        unstable = 0;
        for (int i = 0; i < 34; i++) begin
            tick();
            if (bus.evt_valid !== 1'b1 || bus.evt_port !== hold_p || bus.evt_data !== hold_d)
                unstable++;
        end
        tests_run++;
        if (unstable != 0) begin
            tests_failed++;
            $display("FAIL bp_stable: %0d unstable cycles, required 0", unstable);
        end
        bus.evt_ready = 1'b1;
        repeat (8) tick();
        tests_run++;
        if (ev_port.size() != 2) begin
            tests_failed++;
            $display("FAIL bp_count: %0d events, required 2", ev_port.size());
        end else begin
            tests_run++;
            if (ev_port[0] !== 4'd2 || ev_data[0] !== 8'h22 || ev_port[1] !== 4'd9 || ev_data[1] !== 8'h99) begin
                tests_failed++;
                $display("FAIL bp_order: got {%0d,%h} {%0d,%h}, required {2,22} {9,99}",
                         ev_port[0], ev_data[0], ev_port[1], ev_data[1]);
            end
        end
        scan_en = 1'b0;
    endtask

    task automatic test_mask_setwins();
        logic got;
        apply_reset();
        bad_addr_m      = 0;
        scan_en         = 1'b1;
        bus_m.evt_ready = 1'b1;
        repeat (36) tick();
        bus_m.evt_ready = 1'b0;
        ports[4] = 8'h11;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (bus_m.evt_valid === 1'b1) got = 1'b1;
        end
        tests_run++;
        if (!got || bus_m.evt_port !== 4'd4 || bus_m.evt_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL mask_first: valid=%b port=%0d data=%h, required valid=1 port=4 data=11",
                     bus_m.evt_valid, bus_m.evt_port, bus_m.evt_data);
        end
        ports[4] = 8'h22;
        repeat (8) tick();
        ports[4] = 8'h33;
        repeat (8) tick();
        tests_run++;
        if (bus_m.evt_valid !== 1'b1 || bus_m.evt_port !== 4'd4 || bus_m.evt_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL mask_held: valid=%b port=%0d data=%h, required valid=1 port=4 data=11",
                     bus_m.evt_valid, bus_m.evt_port, bus_m.evt_data);
        end
        bus_m.evt_ready = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (ev_port_m.size() != 2) begin
            tests_failed++;
            $display("FAIL mask_count: %0d events, required 2", ev_port_m.size());
        end else begin
            tests_run++;
            if (ev_port_m[0] !== 4'd4 || ev_data_m[0] !== 8'h11 || ev_port_m[1] !== 4'd4 || ev_data_m[1] !== 8'h33) begin
                tests_failed++;
                $display("FAIL mask_events: got {%0d,%h} {%0d,%h}, required {4,11} {4,33}",
                         ev_port_m[0], ev_data_m[0], ev_port_m[1], ev_data_m[1]);
            end
        end
        tests_run++;
        if (bad_addr_m != 0) begin
            tests_failed++;
            $display("FAIL mask_addr: %0d cycles with in_addr outside {0,4}, required 0", bad_addr_m);
        end
        scan_en = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bad_addr_m   = 0;
        rst_n        = 1'b0;
        scan_en      = 1'b0;
        for (int i = 0; i < 16; i++) ports[i] = 8'h00;
        test_reset();
        test_cpu_read();
        test_prime_change();
        test_fairness();
        test_backpressure();
        test_mask_setwins();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
